// File: rtl/spcore_ctrl_pkg.sv
// Shared constants for the spcore lane controller: opcodes, instruction field
// positions, ALU control codes, write-back mux selects and decode classes.
package spcore_ctrl_pkg;

    localparam int CLK_PERIOD = 10;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_LOADI   = 4'd1;
    localparam logic [3:0] OP_ADD     = 4'd2;
    localparam logic [3:0] OP_MUL     = 4'd3;
    localparam logic [3:0] OP_MAD     = 4'd4;
    localparam logic [3:0] OP_LOADC   = 4'd5;
    localparam logic [3:0] OP_CLEAR   = 4'd6;
    localparam logic [3:0] OP_INC     = 4'd7;
    localparam logic [3:0] OP_SETP_EQ = 4'd8;
    localparam logic [3:0] OP_LOAD    = 4'd9;
    localparam logic [3:0] OP_STORE   = 4'd10;
    localparam logic [3:0] OP_HALT    = 4'd15;

    localparam int OPC_W   = 4;
    localparam int OPC_LSB = 28;
    localparam int X_LSB   = 24;
    localparam int Y_LSB   = 20;
    localparam int Z_LSB   = 16;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] ALUC_ADD     = 4'd0;
    localparam logic [3:0] ALUC_MUL     = 4'd1;
    localparam logic [3:0] ALUC_MAD     = 4'd2;
    localparam logic [3:0] ALUC_CORE_ID = 4'd3;
    localparam logic [3:0] ALUC_CLEAR   = 4'd4;
    localparam logic [3:0] ALUC_INC     = 4'd5;
    localparam logic [3:0] ALUC_EQ      = 4'd6;

    localparam logic [1:0] MuxD_fromI   = 2'd0;
    localparam logic [1:0] MuxD_fromALU = 2'd1;
    localparam logic [1:0] MuxD_fromMem = 2'd2;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_IMM,
        CLS_ALU,
        CLS_SETP,
        CLS_MEM,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXE,
        ST_WB,
        ST_MEM,
        ST_HALTED
    } state_e;

endpackage

// File: rtl/spcore_decode.sv
// Combinational opcode decode: ALU control, write-back mux select and the
// execution class the controller FSM sequences on.
module spcore_decode
    import spcore_ctrl_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [3:0] o_aluc,
    output logic [1:0] o_s2,
    output op_class_e  o_class
);

    always_comb begin
        o_aluc  = ALUC_CLEAR;
        o_s2    = MuxD_fromALU;
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OP_NOP:     o_class = CLS_NOP;
            OP_LOADI:   begin o_class = CLS_IMM;  o_s2   = MuxD_fromI;   end
            OP_ADD:     begin o_class = CLS_ALU;  o_aluc = ALUC_ADD;     end
            OP_MUL:     begin o_class = CLS_ALU;  o_aluc = ALUC_MUL;     end
            OP_MAD:     begin o_class = CLS_ALU;  o_aluc = ALUC_MAD;     end
            OP_LOADC:   begin o_class = CLS_ALU;  o_aluc = ALUC_CORE_ID; end
            OP_CLEAR:   begin o_class = CLS_ALU;  o_aluc = ALUC_CLEAR;   end
            OP_INC:     begin o_class = CLS_ALU;  o_aluc = ALUC_INC;     end
            OP_SETP_EQ: begin o_class = CLS_SETP; o_aluc = ALUC_EQ;      end
            OP_LOAD:    begin o_class = CLS_MEM;  o_aluc = ALUC_ADD; o_s2 = MuxD_fromMem; end
            OP_STORE:   begin o_class = CLS_MEM;  o_aluc = ALUC_ADD;     end
            OP_HALT:    o_class = CLS_HALT;
            default:    o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/spcore_ctrl.sv
// Instruction sequencer for one spcore lane: accepts encoded instructions,
// latches operand fields and steps IDLE/EXE/WB/MEM/HALTED with registered strobes.
module spcore_ctrl
    import spcore_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int REG_AW  = 4,
    parameter int IMM_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [REG_AW-1:0]  x,
    output logic [REG_AW-1:0]  y,
    output logic [REG_AW-1:0]  z,
    output logic [IMM_W-1:0]   I,
    output logic [3:0]         aluc,
    output logic [1:0]         s2,
    output logic               reg_we,
    output logic               en,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    state_e           r_state, w_nxt_state;
    op_class_e        r_class, w_nxt_class, w_dec_class;
    logic             r_store, w_nxt_store;
    logic [OPC_W-1:0] w_opcode;
    logic [3:0]       w_dec_aluc;
    logic [1:0]       w_dec_s2;
    logic             w_accept, w_nxt_illegal, w_ld_ack;

    logic              r_ready, r_reg_we, r_en, r_mem_req, r_mem_we;
    logic              r_busy, r_halted, r_illegal;
    logic [REG_AW-1:0] r_x, r_y, r_z;
    logic [IMM_W-1:0]  r_imm;
    logic [3:0]        r_aluc;
    logic [1:0]        r_s2;

    assign w_opcode = instr[OPC_LSB +: OPC_W];
    assign w_accept = instr_valid & r_ready;

    spcore_decode u_decode (
        .i_opcode (w_opcode),
        .o_aluc   (w_dec_aluc),
        .o_s2     (w_dec_s2),
        .o_class  (w_dec_class)
    );

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_illegal = 1'b0;
        w_nxt_class   = w_accept ? w_dec_class : r_class;
        w_nxt_store   = w_accept ? (w_opcode == OP_STORE) : r_store;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_dec_class)
                        CLS_NOP:     w_nxt_state = ST_IDLE;
                        CLS_ILLEGAL: w_nxt_illegal = 1'b1;
                        CLS_HALT:    w_nxt_state = ST_HALTED;
                        default:     w_nxt_state = ST_EXE;
                    endcase
                end
            end
            ST_EXE: begin
                case (r_class)
                    CLS_ALU: w_nxt_state = ST_WB;
                    CLS_MEM: w_nxt_state = ST_MEM;
                    default: w_nxt_state = ST_IDLE;
                endcase
            end
            ST_WB:     w_nxt_state = ST_IDLE;
            ST_MEM:    if (mem_ack) w_nxt_state = ST_IDLE;
            ST_HALTED: w_nxt_state = ST_HALTED;
            default:   w_nxt_state = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_class   <= CLS_NOP;
            r_store   <= 1'b0;
            r_ready   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_imm     <= '0;
            r_aluc    <= ALUC_CLEAR;
            r_s2      <= MuxD_fromALU;
            r_reg_we  <= 1'b0;
            r_en      <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_class   <= w_nxt_class;
            r_store   <= w_nxt_store;
            r_ready   <= (w_nxt_state == ST_IDLE);
            r_busy    <= (w_nxt_state == ST_EXE) || (w_nxt_state == ST_WB) || (w_nxt_state == ST_MEM);
            r_halted  <= (w_nxt_state == ST_HALTED);
            r_en      <= (w_nxt_state != ST_HALTED);
            r_reg_we  <= ((w_nxt_state == ST_EXE) && (w_nxt_class == CLS_IMM)) || (w_nxt_state == ST_WB);
            r_mem_req <= (w_nxt_state == ST_MEM);
            r_mem_we  <= (w_nxt_state == ST_MEM) && w_nxt_store;
            r_illegal <= w_nxt_illegal;
            if (w_accept) begin
                r_x   <= instr[X_LSB +: REG_AW];
                r_y   <= instr[Y_LSB +: REG_AW];
                r_z   <= instr[Z_LSB +: REG_AW];
                r_imm <= instr[IMM_LSB +: IMM_W];
                if (w_dec_class inside {CLS_ALU, CLS_SETP, CLS_MEM}) r_aluc <= w_dec_aluc;
                if (w_dec_class inside {CLS_IMM, CLS_ALU})           r_s2   <= w_dec_s2;
            end
        end
    end

    // Load data is only valid during the ack cycle, so the load write follows mem_ack directly.
    assign w_ld_ack = reset & (r_state == ST_MEM) & ~r_store & mem_ack;

    assign instr_ready = r_ready;
    assign x           = r_x;
    assign y           = r_y;
    assign z           = r_z;
    assign I           = r_imm;
    assign aluc        = r_aluc;
    assign s2          = w_ld_ack ? MuxD_fromMem : r_s2;
    assign reg_we      = r_reg_we | w_ld_ack;
    assign en          = r_en;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign busy        = r_busy;
    assign halted      = r_halted;
    assign illegal     = r_illegal;

endmodule

// File: doc/spcore_ctrl.md
# spcore_ctrl

Sequencer that drives a single `spcore` lane from encoded instruction words. Each instruction is accepted over a valid/ready handshake, decoded into the core's operand-select, ALU-control, write-back-mux and register-write strobes, and stepped through a multi-cycle state machine. Loads and stores run through a request/acknowledge memory handshake. The block sits between the warp instruction issue logic and one `spcore` instance; one instance is used per core.

## Interface
- `INSTR_W`, 32, instruction word width.
- `REG_AW`, 4, register index width; matches `spcore` x/y/z.
- `IMM_W`, 16, immediate width; matches `spcore` I.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `instr` in `INSTR_W`: opcode[31:28], x[27:24], y[23:20], z[19:16], imm[15:0].
- `instr_valid` in 1: `instr` is presented.
- `instr_ready` out 1: controller can accept an instruction.
- `x`, `y`, `z` out `REG_AW`: register selects to the core.
- `I` out `IMM_W`: immediate to the core.
- `aluc` out 4: ALU operation, using the `ALUC_*` codes.
- `s2` out 2: write-back mux select (`MuxD_fromI`, `MuxD_fromALU`, `MuxD_fromMem`).
- `reg_we` out 1: register-file write strobe.
- `en` out 1: core enable.
- `mem_req` out 1: memory request; address and data come from the core's `addr`/`data_out`.
- `mem_we` out 1: store qualifier for `mem_req`.
- `mem_ack` in 1: memory completion; on a load, read data is valid to the core's `data_in` in the same cycle.
- `busy` out 1: an instruction is in flight.
- `halted` out 1: HALT was executed.
- `illegal` out 1: one-cycle pulse when an undefined opcode is accepted.

## Operation
- Opcodes: 0 NOP, 1 LOADI, 2 ADD, 3 MUL, 4 MAD, 5 LOADC, 6 CLEAR, 7 INC, 8 SETP_EQ, 9 LOAD, 10 STORE, 15 HALT. Codes 11–14 are illegal.
- Opcode to ALU control: ADD→`ALUC_ADD`, MUL→`ALUC_MUL`, MAD→`ALUC_MAD`, LOADC→`ALUC_CORE_ID`, CLEAR→`ALUC_CLEAR`, INC→`ALUC_INC`, SETP_EQ→`ALUC_EQ`. LOAD and STORE use `ALUC_ADD`.
- Field latch: on acceptance (`instr_valid & instr_ready`), the x/y/z/imm fields are latched into the `x`/`y`/`z`/`I` output registers. They hold until the next acceptance.
- States: IDLE, EXE, WB, MEM, HALTED.
- IDLE
  - `instr_ready`=1.
  - On acceptance, go to EXE, except:
    - NOP: stay in IDLE.
    - Illegal opcode: stay in IDLE and pulse `illegal` the next cycle.
    - HALT: go to HALTED.
- EXE
  - LOADI: `s2`=fromI, `reg_we`=1, then IDLE.
  - ALU ops (ADD, MUL, MAD, LOADC, CLEAR, INC): `s2`=fromALU, `reg_we`=0, then WB.
  - SETP_EQ: `reg_we`=0, then IDLE.
  - LOAD and STORE: go to MEM.
- WB
  - `reg_we`=1, `s2` held. Then IDLE.
- MEM
  - `mem_req`=1; `mem_we`=1 for STORE.
  - Held until `mem_ack`.
  - LOAD, on the ack cycle: `s2`=fromMem, `reg_we`=1.
  - Then IDLE.
- HALTED
  - `en`=0, `halted`=1, `instr_ready`=0.
  - Left only by reset.
- `busy` = state is not IDLE and not HALTED.
- `mem_ack` outside MEM is ignored.

## Timing
- Reset values:
  - state=IDLE, `instr_ready`=0 during the reset cycle, then 1.
  - `x`/`y`/`z`/`I`=0, `aluc`=`ALUC_CLEAR`, `s2`=`MuxD_fromALU`.
  - `reg_we`=0, `en`=1, `mem_req`=0, `mem_we`=0, `busy`=0, `halted`=0, `illegal`=0.
- All outputs are registered.
- Latency in cycles after acceptance:
  - LOADI: 1 (write in EXE).
  - ALU ops: 2 (write in WB).
  - SETP_EQ: 1.
  - LOAD/STORE: 2 + ack wait.
- Back-to-back: the next instruction can be accepted in the first IDLE cycle after completion. Issue rate: LOADI every 2 cycles, ALU ops every 3 cycles.
- `reg_we` is never asserted in IDLE or HALTED, and never for more than 1 cycle per instruction.
- `mem_req` stays 1 with `mem_we` stable until the ack; it drops the cycle after the ack.
- Reset low in any state, including MEM mid-wait:
  - Returns to reset values on the next edge.
  - A pending memory request is abandoned.
  - A late `mem_ack` is ignored.

## Structure
- Shared constants header holds the opcode values and field bit positions, alongside the existing `ALUC_*` and `MuxD_*` defines and `CLK_PERIOD`.
- One sub-module, `spcore_decode`: combinational opcode → {`aluc`, `s2`, class (imm/alu/setp/mem/nop/halt/illegal)}.
- The FSM and output registers live in `spcore_ctrl`.

## Test plan
- Register sequence (controller driving a real `spcore`, CORE_ID=100):
  - LOADI x=0 I=11, then LOADI x=1 I=20 → R0=11, R1=20; each writes 1 cycle after acceptance.
  - ADD x=2 y=0 z=1 → `reg_we` low in EXE, high in WB; R2=31.
  - MAD x=2 y=0 z=1 → R2=251. MUL → R2=220.
  - LOADC x=3 → R3=100. CLEAR → R3=0. INC → R3=1.
- SETP_EQ x=1 y=1 → core P=1. No `reg_we` pulse; back in IDLE after 1 cycle.
- STORE with `mem_ack` delayed 3 cycles → `mem_req`=`mem_we`=1 for exactly 4 cycles, then IDLE.
- LOAD with ack data 0x1234 → `reg_we` and `s2`=fromMem on the ack cycle only; target register = 0x1234.
- Reset boundary:
  - Reset driven low while in MEM → next cycle all outputs at reset values.
  - A late `mem_ack` leaves no write.
- Special opcodes:
  - Opcode 12 → `illegal` pulses once; no `reg_we`.
  - HALT → `halted`=1, `en`=0, `instr_ready`=0 until reset.
